// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt arbiter slice.
package irq_pkg;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_t;

  function automatic int id_width(input int src_n);
    return $clog2(src_n + 1);
  endfunction

endpackage

// File: rtl/irq_gateway.sv
// Per-source interrupt gateway: latches a level request until claimed and completed.
module irq_gateway
  import irq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic claim,
  input  logic complete,
  output logic pending
);

  gw_state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GW_IDLE;
    end else begin
      unique case (state)
        GW_IDLE:    if (irq)      state <= GW_PENDING;
        GW_PENDING: if (claim)    state <= GW_CLAIMED;
        GW_CLAIMED: if (complete) state <= GW_IDLE;
        default:                  state <= GW_IDLE;
      endcase
    end
  end

  assign pending = (state == GW_PENDING);

endmodule

// File: rtl/max_finder.sv
// Combinational maximum search over N values with an attached payload.
// Ties resolve to the lowest index; zero-valued entries never win.
module max_finder #(
  parameter int VAL_W = 3,
  parameter int PLD_W = 4,
  parameter int N     = 8
) (
  input  logic [N*VAL_W-1:0] vals,
  input  logic [N*PLD_W-1:0] plds,
  output logic [VAL_W-1:0]   max_val,
  output logic [PLD_W-1:0]   max_pld
);

  always_comb begin
    max_val = '0;
    max_pld = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vals[i*VAL_W +: VAL_W] > max_val) begin
        max_val = vals[i*VAL_W +: VAL_W];
        max_pld = plds[i*PLD_W +: PLD_W];
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: per-source gateways, priority selection and claim/complete handshake.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter  int SRC_N  = 8,
  parameter  int PRIO_W = 3,
  localparam int ID_W   = id_width(SRC_N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SRC_N-1:0]        i_irq,
  input  logic [SRC_N-1:0]        i_enable,
  input  logic [SRC_N*PRIO_W-1:0] i_prio,
  input  logic [PRIO_W-1:0]       i_threshold,
  input  logic                    i_claim,
  output logic [ID_W-1:0]         o_claim_id,
  input  logic                    i_complete,
  input  logic [ID_W-1:0]         i_complete_id,
  output logic                    o_irq,
  output logic [SRC_N-1:0]        o_pending
);

  logic [SRC_N-1:0]        pending;
  logic [SRC_N-1:0]        claim_hit;
  logic [SRC_N-1:0]        complete_hit;
  logic [SRC_N-1:0]        cand;
  logic [SRC_N*PRIO_W-1:0] cand_prio;
  logic [SRC_N*ID_W-1:0]   cand_id;
  logic [PRIO_W-1:0]       win_prio;
  logic [ID_W-1:0]         win_id;
  logic [PRIO_W-1:0]       best_prio;
  logic [ID_W-1:0]         best_id;
  logic [PRIO_W-1:0]       threshold_q;

  for (genvar k = 0; k < SRC_N; k++) begin : g_src
    localparam logic [ID_W-1:0] SRC_ID = ID_W'(k + 1);

    // Claims match the registered winner, so a claim of ID 0 hits nothing.
    assign claim_hit[k]    = i_claim && (best_id == SRC_ID);
    assign complete_hit[k] = i_complete && (i_complete_id == SRC_ID);

    irq_gateway u_gateway (
      .clk      (clk),
      .rst      (rst),
      .irq      (i_irq[k]),
      .claim    (claim_hit[k]),
      .complete (complete_hit[k]),
      .pending  (pending[k])
    );

    assign cand[k] = pending[k] && i_enable[k] && !claim_hit[k]
                     && (i_prio[k*PRIO_W +: PRIO_W] != '0);
    assign cand_prio[k*PRIO_W +: PRIO_W] = cand[k] ? i_prio[k*PRIO_W +: PRIO_W] : '0;
    assign cand_id[k*ID_W +: ID_W]       = SRC_ID;
  end

  max_finder #(
    .VAL_W (PRIO_W),
    .PLD_W (ID_W),
    .N     (SRC_N)
  ) u_max_finder (
    .vals    (cand_prio),
    .plds    (cand_id),
    .max_val (win_prio),
    .max_pld (win_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      best_prio   <= '0;
      best_id     <= '0;
      threshold_q <= '1;
    end else begin
      best_prio   <= win_prio;
      best_id     <= win_id;
      threshold_q <= i_threshold;
    end
  end

  // Both operands are registered, so o_irq behaves as a register output;
  // the all-ones reset threshold keeps it low while in reset.
  assign o_irq      = (best_prio > threshold_q);
  assign o_claim_id = best_id;
  assign o_pending  = pending;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed self-checking bench for irq_arbiter with hand-computed expectations.
module tb_irq_arbiter;

  localparam int SRC_N  = 8;
  localparam int PRIO_W = 3;
  localparam int ID_W   = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [SRC_N-1:0]        irq;
  logic [SRC_N-1:0]        enable;
  logic [SRC_N*PRIO_W-1:0] prio;
  logic [PRIO_W-1:0]       threshold;
  logic                    claim;
  logic [ID_W-1:0]         claim_id;
  logic                    complete;
  logic [ID_W-1:0]         complete_id;
  logic                    irq_out;
  logic [SRC_N-1:0]        pending;

  int checks = 0;
  int errors = 0;

  irq_arbiter #(.SRC_N(SRC_N), .PRIO_W(PRIO_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_irq         (irq),
    .i_enable      (enable),
    .i_prio        (prio),
    .i_threshold   (threshold),
    .i_claim       (claim),
    .o_claim_id    (claim_id),
    .i_complete    (complete),
    .i_complete_id (complete_id),
    .o_irq         (irq_out),
    .o_pending     (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prio(input int src, input int p);
    prio[(src-1)*PRIO_W +: PRIO_W] = PRIO_W'(p);
  endtask

  task automatic do_reset();
    irq = '0; enable = '1; prio = '0; threshold = '0;
    claim = 1'b0; complete = 1'b0; complete_id = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    irq = '1; claim = 1'b1; complete = 1'b1; complete_id = 4'd1;
    prio = '1; rst = 1'b1;
    tick();
    checks++;
    if (claim_id !== 4'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", claim_id); end
    checks++;
    if (irq_out !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b expected 0", irq_out); end
    checks++;
    if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending: got %b expected 00000000", pending); end
    irq = '0; claim = 1'b0; complete = 1'b0; rst = 1'b0;
    tick();
    checks++;
    if (pending !== 8'h00) begin errors++; $display("FAIL reset_release_pending: got %b expected 00000000", pending); end
  endtask

  task automatic test_priority();
    do_reset();
    set_prio(3, 5); set_prio(6, 2);
    irq[2] = 1'b1; irq[5] = 1'b1;
    tick();
    checks++;
    if (pending !== 8'b0010_0100) begin errors++; $display("FAIL prio_pending: got %b expected 00100100", pending); end
    checks++;
    if (claim_id !== 4'd0) begin errors++; $display("FAIL prio_latency_id: got %0d expected 0", claim_id); end
    irq = '0;
    tick();
    checks++;
    if (claim_id !== 4'd3) begin errors++; $display("FAIL prio_id: got %0d expected 3", claim_id); end
    checks++;
    if (irq_out !== 1'b1) begin errors++; $display("FAIL prio_irq: got %0b expected 1", irq_out); end
  endtask

  task automatic test_tie_back_to_back();
    do_reset();
    set_prio(2, 4); set_prio(4, 4);
    irq[1] = 1'b1; irq[3] = 1'b1;
    tick();
    irq = '0;
    tick();
    checks++;
    if (claim_id !== 4'd2) begin errors++; $display("FAIL tie_id: got %0d expected 2", claim_id); end
    claim = 1'b1;
    tick();
    checks++;
    if (claim_id !== 4'd4) begin errors++; $display("FAIL b2b_id: got %0d expected 4", claim_id); end
    checks++;
    if (pending !== 8'b0000_1000) begin errors++; $display("FAIL b2b_pending: got %b expected 00001000", pending); end
    tick();
    claim = 1'b0;
    checks++;
    if (claim_id !== 4'd0) begin errors++; $display("FAIL b2b_empty_id: got %0d expected 0", claim_id); end
    checks++;
    if (irq_out !== 1'b0) begin errors++; $display("FAIL b2b_empty_irq: got %0b expected 0", irq_out); end
  endtask

  task automatic test_threshold();
    do_reset();
    set_prio(1, 3); threshold = 3'd3;
    irq[0] = 1'b1;
    tick();
    irq = '0;
    tick();
    checks++;
    if (irq_out !== 1'b0) begin errors++; $display("FAIL thr_irq_masked: got %0b expected 0", irq_out); end
    checks++;
    if (claim_id !== 4'd1) begin errors++; $display("FAIL thr_id: got %0d expected 1", claim_id); end
    threshold = 3'd2;
    tick();
    checks++;
    if (irq_out !== 1'b1) begin errors++; $display("FAIL thr_irq_open: got %0b expected 1", irq_out); end
  endtask

  task automatic test_complete_reirq();
    do_reset();
    set_prio(5, 1);
    irq[4] = 1'b1;
    tick();
    tick();
    checks++;
    if (claim_id !== 4'd5) begin errors++; $display("FAIL reirq_first_id: got %0d expected 5", claim_id); end
    claim = 1'b1;
    tick();
    claim = 1'b0;
    tick();
    checks++;
    if (pending !== 8'h00) begin errors++; $display("FAIL reirq_claimed_pending: got %b expected 00000000", pending); end
    complete = 1'b1; complete_id = 4'd5;
    tick();
    complete = 1'b0;
    checks++;
    if (pending !== 8'h00) begin errors++; $display("FAIL reirq_idle_pending: got %b expected 00000000", pending); end
    tick();
    checks++;
    if (pending !== 8'b0001_0000) begin errors++; $display("FAIL reirq_repend: got %b expected 00010000", pending); end
    checks++;
    if (claim_id !== 4'd0) begin errors++; $display("FAIL reirq_mid_id: got %0d expected 0", claim_id); end
    tick();
    checks++;
    if (claim_id !== 4'd5) begin errors++; $display("FAIL reirq_again_id: got %0d expected 5", claim_id); end
    irq = '0;
  endtask

  task automatic test_claim_complete_same_cycle();
    do_reset();
    set_prio(2, 4); set_prio(4, 3);
    irq[1] = 1'b1; irq[3] = 1'b1;
    tick();
    irq = '0;
    tick();
    claim = 1'b1;
    tick();
    checks++;
    if (claim_id !== 4'd4) begin errors++; $display("FAIL cc_second_id: got %0d expected 4", claim_id); end
    complete = 1'b1; complete_id = 4'd2;
    tick();
    claim = 1'b0; complete = 1'b0;
    checks++;
    if (pending !== 8'h00 || claim_id !== 4'd0) begin
      errors++; $display("FAIL cc_both: got pending %b id %0d expected 00000000 id 0", pending, claim_id);
    end
    irq[1] = 1'b1; irq[3] = 1'b1;
    tick();
    irq = '0;
    checks++;
    if (pending !== 8'b0000_0010) begin errors++; $display("FAIL cc_src2_idle: got %b expected 00000010", pending); end
  endtask

  task automatic test_ignored();
    do_reset();
    set_prio(7, 2);
    irq[6] = 1'b1;
    tick();
    irq = '0;
    tick();
    complete = 1'b1; complete_id = 4'd7;
    tick();
    complete_id = 4'd0;
    tick();
    complete_id = 4'd15;
    tick();
    complete = 1'b0;
    checks++;
    if (pending !== 8'b0100_0000 || claim_id !== 4'd7) begin
      errors++; $display("FAIL ign_complete: got pending %b id %0d expected 01000000 id 7", pending, claim_id);
    end
    enable[6] = 1'b0;
    tick();
    checks++;
    if (claim_id !== 4'd0 || irq_out !== 1'b0) begin
      errors++; $display("FAIL ign_disabled: got id %0d irq %0b expected id 0 irq 0", claim_id, irq_out);
    end
    claim = 1'b1;
    tick();
    claim = 1'b0;
    checks++;
    if (pending !== 8'b0100_0000 || claim_id !== 4'd0) begin
      errors++; $display("FAIL ign_claim_zero: got pending %b id %0d expected 01000000 id 0", pending, claim_id);
    end
    enable[6] = 1'b1;
    tick();
    checks++;
    if (claim_id !== 4'd7) begin errors++; $display("FAIL ign_reenable_id: got %0d expected 7", claim_id); end
  endtask

  task automatic test_reset_mid_claim();
    do_reset();
    set_prio(2, 3); set_prio(3, 2);
    irq[1] = 1'b1; irq[2] = 1'b1;
    tick();
    irq[1] = 1'b0;
    tick();
    claim = 1'b1;
    tick();
    checks++;
    if (claim_id !== 4'd3) begin errors++; $display("FAIL rmid_pre_id: got %0d expected 3", claim_id); end
    rst = 1'b1; complete = 1'b1; complete_id = 4'd2;
    tick();
    checks++;
    if (claim_id !== 4'd0 || irq_out !== 1'b0 || pending !== 8'h00) begin
      errors++; $display("FAIL rmid_reset: got id %0d irq %0b pending %b expected all 0", claim_id, irq_out, pending);
    end
    rst = 1'b0; claim = 1'b0; complete = 1'b0;
    tick();
    checks++;
    if (pending !== 8'b0000_0100) begin errors++; $display("FAIL rmid_repend: got %b expected 00000100", pending); end
    tick();
    checks++;
    if (claim_id !== 4'd3 || irq_out !== 1'b1) begin
      errors++; $display("FAIL rmid_after: got id %0d irq %0b expected id 3 irq 1", claim_id, irq_out);
    end
    irq = '0;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_tie_back_to_back();
    test_threshold();
    test_complete_reirq();
    test_claim_complete_same_cycle();
    test_ignored();
    test_reset_mid_claim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): SRC_N, 8, number of interrupt sources with IDs 1..SRC_N (ID 0 = none).
REQ-002 PRIO_W, 3, priority width; priority 0 = source never selected.
REQ-003 ID_W, $clog2(SRC_N+1), claim/complete ID width (derived localparam).
REQ-004 Ports SHALL be (name, direction, width, meaning): clk, in, 1, sole clock; reset is synchronous and active-high.
REQ-005 rst, in, 1, synchronous active-high reset.
REQ-006 i_irq, in, SRC_N, level interrupt lines; bit k = source k+1.
REQ-007 i_enable, in, SRC_N, per-source enable.
REQ-008 i_prio, in, SRC_N x PRIO_W, per-source priority.
REQ-009 i_threshold, in, PRIO_W, notification threshold.
REQ-010 i_claim, in, 1, single-cycle claim strobe.
REQ-011 o_claim_id, out, ID_W, ID returned for a claim (valid every cycle).
REQ-012 i_complete, in, 1, single-cycle completion strobe.
REQ-013 i_complete_id, in, ID_W, ID being completed.
REQ-014 o_irq, out, 1, interrupt notification to hart.
REQ-015 o_pending, out, SRC_N, per-source pending flags.

Function
REQ-016 Each source SHALL have a gateway FSM: IDLE, PENDING, CLAIMED.
REQ-017 IDLE -> PENDING when i_irq bit is 1 at a clock edge.
REQ-018 PENDING -> CLAIMED on the edge where i_claim=1 and o_claim_id equals that source.
REQ-019 CLAIMED -> IDLE on the edge where i_complete=1 and i_complete_id equals that source; other transitions hold.
REQ-020 o_pending bit SHALL be 1 iff that gateway is PENDING; IRQ line changes in PENDING/CLAIMED SHALL be ignored.
REQ-021 Candidates = PENDING & enabled & prio>0 & not being claimed this cycle; the max_finder selects highest priority, ties won by lowest ID.
REQ-022 Winner priority and ID SHALL be registered (best_prio, best_id); best_id=0, best_prio=0 when no candidate.
REQ-023 o_claim_id = best_id (registered, no combinational path from i_claim).
REQ-024 o_irq = registered (best_prio > i_threshold); threshold does not affect o_claim_id.
REQ-025 Latency: i_irq rising at edge t -> PENDING after t -> o_irq/o_claim_id updated after edge t+1.
REQ-026 Claim when o_claim_id=0 SHALL change no state and return 0.
REQ-027 Back-to-back claims SHALL never return the same ID twice (claimed source excluded from the same-cycle candidate set).
REQ-028 Complete with ID 0, ID > SRC_N, or ID not in CLAIMED SHALL be ignored.
REQ-029 Claim and complete in the same cycle SHALL both take effect independently.
REQ-030 Complete while i_irq still high: IDLE after that edge, PENDING one edge later.
REQ-031 Disabling a PENDING source SHALL drop it from selection but keep it PENDING.

Reset
REQ-032 rst=1 at an edge SHALL force all gateways IDLE, best_id=0, best_prio=0, o_irq=0, o_pending=0, regardless of claim/complete/irq inputs that cycle.
REQ-033 Reset mid-claim SHALL discard the claim; sources still asserting re-pend on the first edge after rst deasserts.

Structure
REQ-034 Package irq_pkg SHALL hold the gateway state enum (IDLE/PENDING/CLAIMED) and ID-width helper function.
REQ-035 Per-source gateway SHALL be sub-module irq_gateway, instantiated SRC_N times in a generate loop.
REQ-036 Selection SHALL reuse the existing max_finder (VAL_W=PRIO_W, PLD_W=ID_W, payload = source ID).

Verification
REQ-037 Src3 prio 5, src6 prio 2, both enabled, threshold 0, both raised at edge t -> o_irq=1 and o_claim_id=3 after edge t+1.
REQ-038 Src2 and src4 both prio 4 -> o_claim_id=2; claim -> next cycle o_claim_id=4, o_pending=0b0000_1000.
REQ-039 Src1 prio 3, threshold 3 -> o_irq=0 but o_claim_id=1; threshold 2 -> o_irq=1 next edge.
REQ-040 Claim src5 with i_irq[4] held high, complete ID 5 -> IDLE then PENDING; o_claim_id=5 again two edges after complete.
REQ-041 Complete ID 7 while src7 PENDING, and complete ID 0 -> no state change; claim with no candidates -> o_claim_id=0, no change.
REQ-042 Assert rst with src2 CLAIMED and src3 PENDING -> all outputs 0 next edge; src3 still high re-pends after rst release.
